uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  Receive-side controller for the UART RX path; sits directly upstream of the deserializer.
//  Oversamples RX_IN and produces the majority-voted sampled_bit for the deserializer.
//  Sequences the start / data / parity / stop bits and pulses deser_en once per data bit.
//  Checks parity against the deserializer's P_data and checks the stop bit.
//  Raises data_valid for each clean frame. Frame format: 1 start, 8 data (LSB first), optional parity, 1 stop.
// PARAMETERS
//  PRESCALE_W  6  width of Prescale input/edge counter; must hold 32
// PORTS
//  Clk          in   1           system clock (oversampling clock, Prescale x baud)
//  Rst          in   1           reset, asynchronous, active-low
//  RX_IN        in   1           serial line, idle high
//  Prescale     in   PRESCALE_W  oversampling ratio; legal 8/16/32
//  PAR_EN       in   1           1 = parity bit present after data
//  PAR_TYP      in   1           0 = even, 1 = odd
//  P_data       in   8           parallel word returned from deserializer
//  sampled_bit  out  1           majority-voted bit value, to deserializer
//  deser_en     out  1           1-cycle shift strobe, to deserializer
//  data_valid   out  1           1-cycle pulse: frame received with no error
//  par_err      out  1           parity mismatch on last frame (held)
//  stp_err      out  1           stop bit sampled 0 on last frame (held)
// BEHAVIOUR
//  Reset (async, Rst=0): state=IDLE; counters=0; sampled_bit=1; deser_en=0; data_valid=0; par_err=0; stp_err=0.
//   Reset mid-frame aborts the frame; no data_valid is generated for it.
//  Prescale latched into P on IDLE->START. Mid-frame changes are ignored. Values other than 16/32 are treated as 8.
//  edge_cnt counts 0..P-1 within every bit and wraps to 0 at P-1. bit_cnt (0..7) counts data bits.
//  Sampling: RX_IN captured at edge_cnt = P/2-2 and P/2-1. At edge_cnt = P/2, sampled_bit <= majority(s0, s1, RX_IN).
//   sampled_bit is valid from edge_cnt = P/2+1 and is held until the next vote.
//  FSM (Moore; outputs decoded from registered state/counters):
//   IDLE   : RX_IN==0 -> START, edge_cnt=0. Otherwise stay.
//   START  : at edge_cnt==P-1: sampled_bit==0 -> DATA, bit_cnt=0; else -> IDLE (glitch, no flags, no strobe).
//            Entering START clears par_err and stp_err.
//   DATA   : deser_en=1 exactly when edge_cnt==P/2+1. This gives 8 pulses, P clocks apart.
//            At edge_cnt==P-1: if bit_cnt==7 -> PARITY (PAR_EN=1) or STOP (PAR_EN=0); else bit_cnt++.
//   PARITY : at edge_cnt==P-1: par_err <= sampled_bit != (^P_data ^ PAR_TYP); -> STOP.
//   STOP   : at edge_cnt==P-1: stp_err <= ~sampled_bit; data_valid pulses 1 cycle iff no parity error
//            (including the one just computed) and sampled_bit==1; -> IDLE.
//  IDLE is re-entered for at least 1 cycle between frames. A start edge on the first IDLE cycle is accepted.
//  deser_en is never asserted outside DATA. Exactly 8 strobes per completed frame; fewer on glitch or reset.
//  par_err and stp_err hold their value until the next START entry or reset.
//  PAR_EN and PAR_TYP are sampled when used. They must be stable for the frame.
// TESTING
//  P=8, PAR_EN=0, frame 0xA5 -> 8 deser_en pulses 8 clk apart; P_data=0xA5; data_valid=1 for 1 clk; errors 0.
//  P=16, PAR_EN=1, PAR_TYP=0, 0x3C with parity bit 0 -> data_valid pulse, par_err=0. Same frame with parity bit 1 -> par_err=1, no data_valid.
//  P=8, 0x55 with stop bit 0 -> stp_err=1, no data_valid. Next clean frame 0x0F -> stp_err cleared at START, data_valid=1.
//  P=16, RX_IN low for 3 clk then high -> returns to IDLE after 16 clk; deser_en never asserted; flags 0.
//  P=32, 0xC3 with 1-clk inverted spike at edge_cnt=P/2-1 of bit 2 -> majority corrects it; P_data=0xC3, data_valid=1.
//  Rst low during data bit 4 -> all outputs at reset values immediately. Following frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: oversamples RX_IN, majority-votes each bit, sequences
// start/data/parity/stop and reports per-frame parity/stop errors to the host.
module uart_rx_ctrl #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [7:0]            P_data,
  output logic                  sampled_bit,
  output logic                  deser_en,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                r_state;
  logic [PRESCALE_W-1:0] r_p;
  logic [PRESCALE_W-1:0] r_edge_cnt;
  logic [2:0]            r_bit_cnt;
  logic                  r_s0;
  logic                  r_s1;

  logic [PRESCALE_W-1:0] w_p_sel;
  logic [PRESCALE_W-1:0] w_half;
  logic                  w_last;
  logic                  w_vote;

  // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_p_sel = PRESCALE_W'(8);
    if (Prescale == PRESCALE_W'(16) || Prescale == PRESCALE_W'(32)) begin
      w_p_sel = Prescale;
    end
  end

  assign w_half = r_p >> 1;
  assign w_last = (r_edge_cnt == r_p - PRESCALE_W'(1));
  assign w_vote = (r_s0 & r_s1) | (r_s0 & RX_IN) | (r_s1 & RX_IN);

  // NOTE: all state updates here are non-blocking so every register sees the pre-edge value of every other.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state     <= S_IDLE;
      r_p         <= PRESCALE_W'(8);
      r_edge_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_s0        <= 1'b1;
      r_s1        <= 1'b1;
      sampled_bit <= 1'b1;
      deser_en    <= 1'b0;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
    end else begin
      deser_en   <= 1'b0;
      data_valid <= 1'b0;

      // Three-point vote around mid-bit, shared by every non-idle state.
      if (r_state != S_IDLE) begin
        r_edge_cnt <= w_last ? '0 : r_edge_cnt + PRESCALE_W'(1);
        if (r_edge_cnt == w_half - PRESCALE_W'(2)) r_s0 <= RX_IN;
        if (r_edge_cnt == w_half - PRESCALE_W'(1)) r_s1 <= RX_IN;
        if (r_edge_cnt == w_half)                  sampled_bit <= w_vote;
      end

      case (r_state)
        S_IDLE: begin
          if (!RX_IN) begin
            r_state    <= S_START;
            r_edge_cnt <= '0;
            r_p        <= w_p_sel;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
          end
        end

        S_START: begin
          if (w_last) begin
            if (!sampled_bit) begin
              r_state   <= S_DATA;
              r_bit_cnt <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end

        S_DATA: begin
          // Registered one cycle early so the strobe is high at edge_cnt == P/2+1.
          if (r_edge_cnt == w_half) deser_en <= 1'b1;
          if (w_last) begin
            if (r_bit_cnt == 3'd7) begin
              r_state <= PAR_EN ? S_PARITY : S_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end

        S_PARITY: begin
          if (w_last) begin
            par_err <= (sampled_bit != (^P_data ^ PAR_TYP));
            r_state <= S_STOP;
          end
        end

        S_STOP: begin
          if (w_last) begin
            stp_err    <= ~sampled_bit;
            data_valid <= ~par_err & sampled_bit;
            r_state    <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: frames are serialised at the oversampled rate, expected
// outcomes are queued per frame and a monitor checks them when the frame completes.
module tb_uart_rx_ctrl;

  typedef struct {
    logic [7:0] data;
    int         p;
    bit         par_en;
    bit         valid;
    bit         par_err;
    bit         stp_err;
  } exp_t;

  logic       Clk;
  logic       Rst;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_data;
  logic       sampled_bit;
  logic       deser_en;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  uart_rx_ctrl #(.PRESCALE_W(6)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .RX_IN      (RX_IN),
    .Prescale   (Prescale),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_data     (P_data),
    .sampled_bit(sampled_bit),
    .deser_en   (deser_en),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Downstream deserializer: shifts sampled bits in LSB first.
  always @(posedge Clk or negedge Rst) begin
    if (!Rst)          P_data <= '0;
    else if (deser_en) P_data <= {sampled_bit, P_data[7:1]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sampled_bit"}, sampled_bit, 1);
    check({tag, "_deser_en"},    deser_en,    0);
    check({tag, "_data_valid"},  data_valid,  0);
    check({tag, "_par_err"},     par_err,     0);
    check({tag, "_stp_err"},     stp_err,     0);
  endtask

  // Serialise one frame. spike_bit inverts one cycle near mid-bit of that frame bit;
  // abort_bit pulls reset in the middle of that frame bit and abandons the frame.
  task automatic send_frame(input logic [7:0] data, input int presc, input bit par_en,
                            input bit par_typ, input bit bad_par, input bit stop_bit,
                            input int spike_bit, input int abort_bit, input int gap);
    int         p;
    int         nb;
    logic [10:0] bits;
    exp_t       e;
    p = (presc == 16) ? 16 : (presc == 32) ? 32 : 8;
    bits = '0;
    for (int i = 0; i < 8; i++) bits[1+i] = data[i];
    if (par_en) begin
      bits[9]  = (^data) ^ par_typ ^ bad_par;
      bits[10] = stop_bit;
      nb = 11;
    end else begin
      bits[9] = stop_bit;
      nb = 10;
    end
    if (abort_bit < 0) begin
      e.data    = data;
      e.p       = p;
      e.par_en  = par_en;
      e.par_err = par_en && bad_par;
      e.stp_err = !stop_bit;
      e.valid   = !e.par_err && !e.stp_err;
      exp_q.push_back(e);
    end
    Prescale = 6'(presc);
    PAR_EN   = par_en;
    PAR_TYP  = par_typ;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < p; c++) begin
        @(negedge Clk);
        if (b == abort_bit && c == p / 2) begin
          Rst = 1'b0;
          #1;
          check_reset_outputs("abort");
          RX_IN = 1'b1;
          repeat (3) @(negedge Clk);
          Rst = 1'b1;
          repeat (3) @(negedge Clk);
          return;
        end
        RX_IN = bits[b] ^ (b == spike_bit && c == p / 2);
        if (b == 1 && c == 0) Prescale = 6'($urandom_range(0, 63));
        if (b == 0 && c == 2) begin
          check("flags_clear_par", par_err, 0);
          check("flags_clear_stp", stp_err, 0);
        end
      end
    end
    RX_IN = 1'b1;
    repeat (gap) @(negedge Clk);
  endtask

  // Monitor: gathers 8 strobes, pops the expected frame, then judges the frame
  // on the cycle data_valid is due (the first IDLE cycle after the stop bit).
  initial begin : monitor
    int   strobes;
    int   tail;
    int   cyc;
    int   vcount;
    int   t[8];
    exp_t cur;
    strobes = 0;
    tail    = -1;
    cyc     = 0;
    vcount  = 0;
    forever begin
      @(negedge Clk);
      cyc++;
      if (!Rst) begin
        strobes = 0;
        tail    = -1;
        continue;
      end
      if (tail >= 0) begin
        if (deser_en) check("extra_strobe", deser_en, 0);
        if (data_valid) vcount++;
        if (tail == 0) begin
          check("p_data",        P_data,     cur.data);
          check("data_valid",    data_valid, cur.valid);
          check("valid_pulses",  vcount,     cur.valid);
          check("par_err",       par_err,    cur.par_err);
          check("stp_err",       stp_err,    cur.stp_err);
          tail = -1;
        end else begin
          tail--;
        end
      end else begin
        if (data_valid) check("stray_valid", data_valid, 0);
        if (deser_en) begin
          t[strobes] = cyc;
          strobes++;
          if (strobes == 8) begin
            strobes = 0;
            if (exp_q.size() == 0) begin
              check("unexpected_frame", 1, 0);
            end else begin
              cur = exp_q.pop_front();
              for (int i = 1; i < 8; i++) check("strobe_gap", t[i] - t[i-1], cur.p);
              tail   = (cur.par_en ? 3 : 2) * cur.p - cur.p / 2 - 2;
              vcount = 0;
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    Rst      = 1'b0;
    RX_IN    = 1'b1;
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    repeat (3) @(negedge Clk);
    check_reset_outputs("reset");
    Rst = 1'b1;
    repeat (3) @(negedge Clk);

    // data, presc, par_en, par_typ, bad_par, stop, spike, abort, gap
    send_frame(8'hA5,  8, 0, 0, 0, 1, -1, -1, 3);
    send_frame(8'h3C, 16, 1, 0, 0, 1, -1, -1, 3);
    send_frame(8'h3C, 16, 1, 0, 1, 1, -1, -1, 3);
    send_frame(8'h55,  8, 0, 0, 0, 0, -1, -1, 3);
    send_frame(8'h0F,  8, 0, 0, 0, 1, -1, -1, 2);

    // Start glitch: 3 low cycles, then the line returns high for the rest of the bit.
    Prescale = 6'd16;
    PAR_EN   = 1'b0;
    n = 0;
    for (int c = 0; c < 17; c++) begin
      @(negedge Clk);
      RX_IN = (c >= 3);
      n += int'(deser_en);
    end
    check("glitch_strobes",     n,           0);
    check("glitch_sampled_bit", sampled_bit, 1);
    check("glitch_par_err",     par_err,     0);
    check("glitch_stp_err",     stp_err,     0);

    send_frame(8'hC3, 32, 0, 0, 0, 1, 3, -1, 3);
    send_frame(8'h99,  8, 0, 0, 0, 1, -1, 5, 0);
    send_frame(8'h81,  8, 0, 0, 0, 1, -1, -1, 3);

    for (int k = 0; k < 40; k++) begin
      int presc;
      case ($urandom_range(0, 4))
        0:       presc = 8;
        1:       presc = 16;
        2:       presc = 32;
        3:       presc = 5;
        default: presc = 40;
      endcase
      send_frame(8'($urandom_range(0, 255)), presc, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : -1,
                 -1, int'($urandom_range(2, 5)));
    end

    repeat (8) @(negedge Clk);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
